// File: rtl/slave_control.sv
// Slave side of a request/ack handshake with a master chip: synchronizes the master's
// signals, notifies the user, and latches data after a local accept. Optional: SLAVE_TIMEOUT_EN.
module slave_control #(
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int CNT_W          = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       request_in,
    input  logic       valid_in,
    input  logic [2:0] data_in,
    input  logic       accept,
    output logic       ack,
    output logic       notice_slave,
    output logic [2:0] data_out,
    output logic       data_valid,
    output logic       timeout
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NOTICE = 2'b01;
    localparam logic [1:0] ACK    = 2'b10;
    localparam logic [1:0] DONE   = 2'b11;

    // The timeout counter must be able to reach TIMEOUT_CYCLES-1.
    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
        $error("slave_control: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    logic       req_m, req_s;
    logic       valid_m, valid_s;
    logic [2:0] data_m, data_s;
    logic [1:0] state, next_state;
    logic       to_hit;

    // Master signals are asynchronous to clk; only the second flop feeds the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_m   <= 1'b0;
            req_s   <= 1'b0;
            valid_m <= 1'b0;
            valid_s <= 1'b0;
            data_m  <= 3'b000;
            data_s  <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments make the two stages shift together; blocking would collapse them into one flop.
            req_m   <= request_in;
            req_s   <= req_m;
            valid_m <= valid_in;
            valid_s <= valid_m;
            data_m  <= data_in;
            data_s  <= data_m;
        end
    end

`ifdef SLAVE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign to_hit = (state == ACK) && !valid_s && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= to_hit;
            if (state == NOTICE && next_state == ACK)
                cnt <= '0;
            else if (state == ACK)
                cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:   if (req_s) next_state = NOTICE;
            NOTICE: begin
                if (!req_s)      next_state = IDLE;
                else if (accept) next_state = ACK;
            end
            ACK: begin
                // Valid wins over a simultaneous request drop or timeout.
                if (valid_s)               next_state = DONE;
                else if (!req_s || to_hit) next_state = IDLE;
            end
            DONE:   if (!req_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ack/notice_slave decode next_state so they switch on the same edge as state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ack          <= 1'b0;
            notice_slave <= 1'b0;
            data_out     <= 3'b000;
            data_valid   <= 1'b0;
        end else begin
            state        <= next_state;
            ack          <= (next_state == ACK);
            notice_slave <= (next_state == NOTICE) || (next_state == ACK);
            if (state == ACK && valid_s) begin
                data_out   <= data_s;
                data_valid <= 1'b1;
            end else if (state == NOTICE && next_state == ACK) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_slave_control.sv
// Self-checking bench for slave_control: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_slave_control;

    localparam int TB_TIMEOUT = 8;
    localparam int TB_CNT_W   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       request_in = 1'b0;
    logic       valid_in = 1'b0;
    logic [2:0] data_in = 3'b000;
    logic       accept = 1'b0;
    logic       ack, notice_slave, data_valid, timeout;
    logic [2:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    slave_control #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .request_in   (request_in),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .accept       (accept),
        .ack          (ack),
        .notice_slave (notice_slave),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Transfer phases: waiting for the master, user notified, granted (ack up), delivered.
    typedef enum int {P_WAIT, P_NOTICED, P_GRANTED, P_DELIVERED} phase_t;
`ifdef SLAVE_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    phase_t     phase = P_WAIT;
    int         granted_cycles = 0;
    logic [1:0] m_req = 2'b00;   // [1] is the copy the protocol sees this edge
    logic [1:0] m_val = 2'b00;
    logic [2:0] m_dat [2];
    logic       r, v;
    logic [2:0] d;
    logic       exp_ack = 1'b0, exp_notice = 1'b0, exp_dv = 1'b0, exp_to = 1'b0;
    logic [2:0] exp_data = 3'b000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = P_WAIT;
            granted_cycles = 0;
            m_req = 2'b00; m_val = 2'b00; m_dat[0] = 3'b000; m_dat[1] = 3'b000;
            exp_ack = 1'b0; exp_notice = 1'b0; exp_dv = 1'b0; exp_to = 1'b0; exp_data = 3'b000;
        end else begin
            r = m_req[1]; v = m_val[1]; d = m_dat[1];
            exp_to = 1'b0;
            case (phase)
                P_WAIT:      if (r) phase = P_NOTICED;
                P_NOTICED: begin
                    if (!r) phase = P_WAIT;
                    else if (accept) begin
                        phase = P_GRANTED; exp_dv = 1'b0; granted_cycles = 0;
                    end
                end
                P_GRANTED: begin
                    granted_cycles++;
                    if (v) begin
                        exp_data = d; exp_dv = 1'b1; phase = P_DELIVERED;
                    end else if (TIMEOUT_ON && granted_cycles == TB_TIMEOUT) begin
                        exp_to = 1'b1; phase = P_WAIT;
                    end else if (!r) phase = P_WAIT;
                end
                P_DELIVERED: if (!r) phase = P_WAIT;
                default:     phase = P_WAIT;
            endcase
            exp_ack    = (phase == P_GRANTED);
            exp_notice = (phase == P_NOTICED) || (phase == P_GRANTED);
            m_req = {m_req[0], request_in};
            m_val = {m_val[0], valid_in};
            m_dat[1] = m_dat[0]; m_dat[0] = data_in;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("ack", 32'(ack), 32'(exp_ack));
            check("notice_slave", 32'(notice_slave), 32'(exp_notice));
            check("data_out", 32'(data_out), 32'(exp_data));
            check("data_valid", 32'(data_valid), 32'(exp_dv));
            check("timeout", 32'(timeout), 32'(exp_to));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_accept();
        accept = 1'b1;
        tick(1);
        accept = 1'b0;
    endtask

    task automatic transfer(input logic [2:0] val);
        request_in = 1'b1;
        tick(3);
        pulse_accept();
        valid_in = 1'b1; data_in = val;
        tick(3);
        request_in = 1'b0; valid_in = 1'b0;
        tick(3);
    endtask

    int n_ack, n_to;

    initial begin
        m_dat[0] = 3'b000; m_dat[1] = 3'b000;
        tick(2);
        check("reset ack", 32'(ack), 0);
        check("reset data_out", 32'(data_out), 0);
        rst = 1'b0;
        tick(2);
        check("idle notice", 32'(notice_slave), 0);

        // Full transfer with 3'b101.
        request_in = 1'b1;
        tick(3);
        check("full notice", 32'(notice_slave), 1);
        check("full ack before accept", 32'(ack), 0);
        pulse_accept();
        check("full ack", 32'(ack), 1);
        valid_in = 1'b1; data_in = 3'b101;
        tick(2);
        check("full dv before 3rd edge", 32'(data_valid), 0);
        tick(1);
        check("full data_out", 32'(data_out), 32'h5);
        check("full data_valid", 32'(data_valid), 1);
        check("full ack in done", 32'(ack), 0);
        request_in = 1'b0; valid_in = 1'b0;
        tick(3);
        check("full idle ack", 32'(ack), 0);
        check("full hold data", 32'(data_out), 32'h5);

        // Early accept is ignored while idle.
        pulse_accept();
        request_in = 1'b1;
        tick(5);
        check("early notice", 32'(notice_slave), 1);
        check("early ack", 32'(ack), 0);
        pulse_accept();
        check("early ack after 2nd", 32'(ack), 1);
        check("early dv cleared", 32'(data_valid), 0);
        request_in = 1'b0;
        tick(3);
        check("early ack dropped", 32'(ack), 0);

        // Master abort in NOTICE.
        request_in = 1'b1;
        tick(3);
        check("abort notice", 32'(notice_slave), 1);
        request_in = 1'b0;
        tick(3);
        check("abort notice off", 32'(notice_slave), 0);
        check("abort data kept", 32'(data_out), 32'h5);

        // Asynchronous reset while ack is high; request stays high across it.
        request_in = 1'b1;
        tick(3);
        pulse_accept();
        check("rst pre ack", 32'(ack), 1);
        #2 rst = 1'b1;
        #1;
        check("rst async ack", 32'(ack), 0);
        check("rst async notice", 32'(notice_slave), 0);
        check("rst async data_out", 32'(data_out), 0);
        tick(1);
        rst = 1'b0;
        tick(3);
        check("rst restart notice", 32'(notice_slave), 1);
        request_in = 1'b0;
        tick(3);

        // Back-to-back transfers.
        transfer(3'b011);
        check("b2b first data", 32'(data_out), 32'h3);
        request_in = 1'b1;
        tick(3);
        pulse_accept();
        check("b2b dv cleared", 32'(data_valid), 0);
        valid_in = 1'b1; data_in = 3'b110;
        tick(3);
        request_in = 1'b0; valid_in = 1'b0;
        tick(3);
        check("b2b final data", 32'(data_out), 32'h6);
        check("b2b final dv", 32'(data_valid), 1);

        // Accept with no valid: timeout (when built in) or indefinite wait.
        request_in = 1'b1;
        tick(3);
        pulse_accept();
        n_ack = 0; n_to = 0;
        for (int i = 0; i < 20; i++) begin
            if (ack) n_ack++;
            if (timeout) n_to++;
            tick(1);
        end
`ifdef SLAVE_TIMEOUT_EN
        check("timeout ack cycles", 32'(n_ack), 8);
        check("timeout pulses", 32'(n_to), 1);
`else
        check("no-timeout ack cycles", 32'(n_ack), 20);
        check("no-timeout pulses", 32'(n_to), 0);
`endif
        check("timeout dv", 32'(data_valid), 0);
        request_in = 1'b0;
        tick(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            accept = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) request_in = ~request_in;
            if ($urandom_range(0, 5) == 0) valid_in = ~valid_in;
            if ($urandom_range(0, 3) == 0) data_in = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            tick(1);
            rst = 1'b0;
        end
        accept = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
